// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core and its SQI serial-SRAM responder.
package idli_pkg;

  typedef logic [3:0] slice_t;

  typedef enum logic [7:0] {
    SQI_CMD_WRITE = 8'h02,
    SQI_CMD_READ  = 8'h03
  } sqi_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    READ,
    WRITE,
    IGNORE
  } sqi_sram_state_t;

  localparam int SQI_ADDR_BEATS  = 6;
  localparam int SQI_DUMMY_BEATS = 2;

endpackage

// File: rtl/idli_sqi_sram_array_m.sv
// Byte RAM: one registered read port, a serial write port and a backdoor write port.
// The serial port wins when both write the same byte on the same edge.
module idli_sqi_sram_array_m #(
  parameter int MEM_BYTES = 65536,
  parameter int AW        = $clog2(MEM_BYTES)
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_bd_wr_en,
  input  logic [AW-1:0] i_bd_addr,
  input  logic [7:0]    i_bd_data
);

  logic [7:0] r_mem [MEM_BYTES];
  logic [7:0] r_rd_data;
  logic       w_bd_blocked;

  assign w_bd_blocked = i_wr_en && (i_bd_addr == i_wr_addr);

  always_ff @(posedge i_clk) begin
    if (i_bd_wr_en && !w_bd_blocked) begin
      r_mem[i_bd_addr] <= i_bd_data;
    end
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/idli_sqi_sram_m.sv
// SQI serial-SRAM responder: decodes READ (0x03) / WRITE (0x02) nibble streams.
// Define IDLI_SQI_SRAM_BACKDOOR_EN to add the backdoor preload write port.
module idli_sqi_sram_m
  import idli_pkg::*;
#(
  parameter int MEM_BYTES = 65536
) (
  input  logic   i_sram_gck,
  input  logic   i_sram_rst,
  input  logic   i_sram_sck,
  input  logic   i_sram_cs,
  input  slice_t i_sram_sio,
  output slice_t o_sram_sio,
  output logic   o_sram_sio_en
`ifdef IDLI_SQI_SRAM_BACKDOOR_EN
  ,
  input  logic        i_sram_bd_wr,
  input  logic [23:0] i_sram_bd_addr,
  input  logic [7:0]  i_sram_bd_data
`endif
);

  localparam int AW = $clog2(MEM_BYTES);

  sqi_sram_state_t r_state, w_state_next;
  logic [2:0]      r_cnt, w_cnt_next;
  logic [AW-1:0]   r_addr, w_addr_next;
  slice_t          r_nib, w_nib_next;
  logic            r_half, w_half_next;
  logic            r_is_read, w_is_read_next;
  slice_t          r_sio, w_sio_next;
  logic            r_sio_en, w_sio_en_next;

  logic            w_wr_en;
  logic [7:0]      w_cmd;
  logic [7:0]      w_rd_data;
  logic            w_bd_wr_en;
  logic [AW-1:0]   w_bd_addr;
  logic [7:0]      w_bd_data;

`ifdef IDLI_SQI_SRAM_BACKDOOR_EN
  assign w_bd_wr_en = i_sram_bd_wr;
  assign w_bd_addr  = AW'(i_sram_bd_addr);
  assign w_bd_data  = i_sram_bd_data;
`else
  assign w_bd_wr_en = 1'b0;
  assign w_bd_addr  = '0;
  assign w_bd_data  = '0;
`endif

  assign w_cmd = {r_nib, i_sram_sio};

  always_ff @(posedge i_sram_gck or posedge i_sram_rst) begin
    if (i_sram_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_nib     <= '0;
      r_half    <= 1'b0;
      r_is_read <= 1'b0;
      r_sio     <= '0;
      r_sio_en  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_addr    <= w_addr_next;
      r_nib     <= w_nib_next;
      r_half    <= w_half_next;
      r_is_read <= w_is_read_next;
      r_sio     <= w_sio_next;
      r_sio_en  <= w_sio_en_next;
    end
  end

  // The read port always tracks r_addr, so the byte to present next is
  // already in w_rd_data when its high-nibble beat arrives.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_addr_next    = r_addr;
    w_nib_next     = r_nib;
    w_half_next    = r_half;
    w_is_read_next = r_is_read;
    w_sio_next     = r_sio;
    w_sio_en_next  = r_sio_en;
    w_wr_en        = 1'b0;

    if (i_sram_cs) begin
      w_state_next  = IDLE;
      w_cnt_next    = '0;
      w_half_next   = 1'b0;
      w_sio_en_next = 1'b0;
    end else if (i_sram_sck) begin
      unique case (r_state)
        IDLE: begin
          w_nib_next   = i_sram_sio;
          w_state_next = CMD;
        end
        CMD: begin
          w_cnt_next = '0;
          if (w_cmd == SQI_CMD_READ) begin
            w_is_read_next = 1'b1;
            w_state_next   = ADDR;
          end else if (w_cmd == SQI_CMD_WRITE) begin
            w_is_read_next = 1'b0;
            w_state_next   = ADDR;
          end else begin
            w_state_next = IGNORE;
          end
        end
        ADDR: begin
          w_addr_next = (r_addr << 4) | AW'(i_sram_sio);
          if (r_cnt == 3'(SQI_ADDR_BEATS - 1)) begin
            w_cnt_next   = '0;
            w_half_next  = 1'b0;
            w_state_next = r_is_read ? DUMMY : WRITE;
          end else begin
            w_cnt_next = r_cnt + 3'd1;
          end
        end
        DUMMY: begin
          if (r_cnt == 3'(SQI_DUMMY_BEATS - 1)) begin
            w_cnt_next    = '0;
            w_sio_next    = w_rd_data[7:4];
            w_nib_next    = w_rd_data[3:0];
            w_addr_next   = r_addr + AW'(1);
            w_half_next   = 1'b1;
            w_sio_en_next = 1'b1;
            w_state_next  = READ;
          end else begin
            w_cnt_next = r_cnt + 3'd1;
          end
        end
        READ: begin
          if (r_half) begin
            w_sio_next  = r_nib;
            w_half_next = 1'b0;
          end else begin
            w_sio_next  = w_rd_data[7:4];
            w_nib_next  = w_rd_data[3:0];
            w_addr_next = r_addr + AW'(1);
            w_half_next = 1'b1;
          end
        end
        WRITE: begin
          if (r_half) begin
            w_wr_en     = 1'b1;
            w_addr_next = r_addr + AW'(1);
            w_half_next = 1'b0;
          end else begin
            w_nib_next  = i_sram_sio;
            w_half_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  idli_sqi_sram_array_m #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
    .i_clk      (i_sram_gck),
    .i_rd_addr  (r_addr),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_addr  (r_addr),
    .i_wr_data  (w_cmd),
    .i_bd_wr_en (w_bd_wr_en),
    .i_bd_addr  (w_bd_addr),
    .i_bd_data  (w_bd_data)
  );

  assign o_sram_sio    = r_sio;
  assign o_sram_sio_en = r_sio_en;

endmodule

// File: tb/tb_idli_sqi_sram_m.sv
// Bench for idli_sqi_sram_m: a 64 KiB and a 1 KiB instance against a byte-map model.
module tb_idli_sqi_sram_m;
  import idli_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   sck;
  logic   cs0, cs1;
  slice_t sio_in;
  slice_t sio0, sio1;
  logic   en0, en1;
`ifdef IDLI_SQI_SRAM_BACKDOOR_EN
  logic        bd_wr;
  logic [23:0] bd_addr;
  logic [7:0]  bd_data;
`endif

  always #5 clk = ~clk;

  idli_sqi_sram_m #(.MEM_BYTES(65536)) u_dut0 (
    .i_sram_gck    (clk),
    .i_sram_rst    (rst),
    .i_sram_sck    (sck),
    .i_sram_cs     (cs0),
    .i_sram_sio    (sio_in),
    .o_sram_sio    (sio0),
    .o_sram_sio_en (en0)
`ifdef IDLI_SQI_SRAM_BACKDOOR_EN
    ,
    .i_sram_bd_wr   (bd_wr),
    .i_sram_bd_addr (bd_addr),
    .i_sram_bd_data (bd_data)
`endif
  );

  idli_sqi_sram_m #(.MEM_BYTES(1024)) u_dut1 (
    .i_sram_gck    (clk),
    .i_sram_rst    (rst),
    .i_sram_sck    (sck),
    .i_sram_cs     (cs1),
    .i_sram_sio    (sio_in),
    .o_sram_sio    (sio1),
    .o_sram_sio_en (en1)
`ifdef IDLI_SQI_SRAM_BACKDOOR_EN
    ,
    .i_sram_bd_wr   (bd_wr),
    .i_sram_bd_addr (bd_addr),
    .i_sram_bd_data (bd_data)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;
  int gap     = 0;
  logic [7:0] mdl [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int key(input int s, input logic [23:0] a);
    int sz;
    sz = (s == 1) ? 1024 : 65536;
    return s * (1 << 24) + (int'(a) % sz);
  endfunction

  task automatic beat(input slice_t n, output slice_t o, output logic e);
    @(negedge clk);
    o = (sel == 1) ? sio1 : sio0;
    e = (sel == 1) ? en1 : en0;
    sio_in = n;
    sck = 1'b1;
    if (gap > 0) begin
      @(negedge clk);
      sck = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic start();
    cs0 = (sel != 0);
    cs1 = (sel != 1);
  endtask

  task automatic stop();
    @(negedge clk);
    sck = 1'b0;
    cs0 = 1'b1;
    cs1 = 1'b1;
    @(negedge clk);
    chk("en_after_cs", (sel == 1) ? en1 : en0, 1'b0);
  endtask

  task automatic hdr(input logic [7:0] cmd, input logic [23:0] addr);
    slice_t o;
    logic   e;
    logic [31:0] word;
    word = {cmd, addr};
    for (int i = 7; i >= 0; i--) beat(word[i*4 +: 4], o, e);
  endtask

  task automatic sqi_write(input logic [23:0] addr, input logic [7:0] bytes[$]);
    slice_t o;
    logic   e;
    start();
    hdr(8'h02, addr);
    foreach (bytes[i]) begin
      beat(bytes[i][7:4], o, e);
      beat(bytes[i][3:0], o, e);
      mdl[key(sel, addr + 24'(i))] = bytes[i];
    end
    stop();
  endtask

  task automatic sqi_read(input logic [23:0] addr, input int nbytes);
    slice_t o;
    logic   e;
    logic [7:0] exp;
    start();
    hdr(8'h03, addr);
    beat(4'h0, o, e);
    chk("en_dummy1", e, 1'b0);
    beat(4'h0, o, e);
    chk("en_dummy2", e, 1'b0);
    for (int i = 0; i < nbytes; i++) begin
      exp = mdl[key(sel, addr + 24'(i))];
      beat(4'h0, o, e);
      chk($sformatf("rd_hi[%0h+%0d]", addr, i), o, exp[7:4]);
      chk("rd_en", e, 1'b1);
      beat(4'h0, o, e);
      chk($sformatf("rd_lo[%0h+%0d]", addr, i), o, exp[3:0]);
    end
    stop();
  endtask

  task automatic aborted_write(input logic [23:0] addr);
    slice_t o;
    logic   e;
    start();
    hdr(8'h02, addr);
    beat(4'hF, o, e);
    @(negedge clk);
    sio_in = 4'h0;
    sck = 1'b1;
    cs0 = 1'b1;
    cs1 = 1'b1;
    @(negedge clk);
    sck = 1'b0;
    chk("abort_en", (sel == 1) ? en1 : en0, 1'b0);
  endtask

  initial begin
    logic [7:0] q[$];
    slice_t o;
    logic   e;
    int     len;
    logic [23:0] a;

    rst = 1'b1; sck = 1'b0; cs0 = 1'b1; cs1 = 1'b1; sio_in = '0;
`ifdef IDLI_SQI_SRAM_BACKDOOR_EN
    bd_wr = 1'b0; bd_addr = '0; bd_data = '0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_sio0", sio0, 4'h0);
    chk("rst_en0", en0, 1'b0);
    chk("rst_en1", en1, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // write 12 34 56 at 0x20, read back 6 nibbles
    sel = 0; gap = 0;
    q = '{8'h12, 8'h34, 8'h56};
    sqi_write(24'h000020, q);
    sqi_read(24'h000020, 3);

    // reset mid-ADDR with cs low; o_sram_sio still holds the last read nibble
    start();
    beat(4'h0, o, e); beat(4'h2, o, e);
    beat(4'h0, o, e); beat(4'h0, o, e); beat(4'h0, o, e);
    @(negedge clk);
    sck = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midaddr_rst_sio", sio0, 4'h0);
    chk("midaddr_rst_en", en0, 1'b0);
    rst = 1'b0;
    stop();
    q = '{8'hA5};
    sqi_write(24'h000010, q);
    sqi_read(24'h000010, 1);

    // wrap at the end of the 1 KiB instance
    sel = 1;
    q = '{8'hAB, 8'hCD};
    sqi_write(24'h0003FF, q);
    sqi_read(24'h0003FF, 2);
    sqi_read(24'h000000, 1);

    // unknown command is consumed silently
    sel = 0;
    q = '{8'h5A};
    sqi_write(24'h000000, q);
    start();
    beat(4'h9, o, e);
    beat(4'hF, o, e);
    for (int i = 0; i < 10; i++) begin
      beat(slice_t'($urandom_range(0, 15)), o, e);
      chk("badcmd_en", e, 1'b0);
    end
    stop();
    sqi_read(24'h000000, 1);

    // half-received write byte is dropped when cs rises with the next beat
    q = '{8'h77};
    sqi_write(24'h000030, q);
    aborted_write(24'h000030);
    sqi_read(24'h000030, 1);
    gap = 3;
    aborted_write(24'h000030);
    sqi_read(24'h000030, 1);
    gap = 0;

`ifdef IDLI_SQI_SRAM_BACKDOOR_EN
    @(negedge clk);
    bd_wr = 1'b1; bd_addr = 24'h000040; bd_data = 8'hC3;
    @(negedge clk);
    bd_wr = 1'b0;
    mdl[key(0, 24'h000040)] = 8'hC3;
    mdl[key(1, 24'h000040)] = 8'hC3;
    sel = 0;
    sqi_read(24'h000040, 1);
    sel = 1;
    sqi_read(24'h000040, 1);
`endif

    // randomized write/read-back, including wrap-around and beat gaps
    for (int t = 0; t < 24; t++) begin
      sel = int'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 4));
      a = 24'($urandom);
      if (t % 4 == 0) a = (sel == 1) ? 24'h0003FE : 24'h00FFFE;
      q = {};
      for (int i = 0; i < len; i++) q.push_back(8'($urandom));
      sqi_write(a, q);
      sqi_read(a, len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
